con_reader: RTL and testbench

Serial game-controller reader that polls a SNES-protocol pad on GPIO pins and produces the 16-bit `con_state` word consumed by the HPS input PIO. It sits between the GPIO pins (via `ioss`) and the SoC's `input_pio_export`. It generates the latch and clock waveforms and synchronises the serial data line. After each full 16-bit read it publishes one coherent, active-high button word.

---
 rtl/con_reader.sv | 169 ++++++++++++++++
 tb/tb_con_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/con_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// con_reader: polls a SNES-protocol pad and publishes an active-high 16-bit
// button word.  Rev 1.0
// ----------------------------------------------------------------------------
module con_reader #(
  parameter int POLL_CYCLES  = 833333,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        poll_req,
  input  logic        con_data,
  output logic        con_latch,
  output logic        con_clk,
  output logic [15:0] con_state,
  output logic        state_valid,
  output logic        busy
);

  localparam int PCW    = $clog2(POLL_CYCLES + 1);
  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW     = $clog2(PH_MAX + 1);

  localparam logic [PCW-1:0] PC_LAST    = PCW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0]  LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0]  HALF_LAST  = CW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [1:0]      sync_q;
  logic            data_s;
  logic [PCW-1:0]  pc;
  logic [CW-1:0]   cnt;
  logic [3:0]      bi;
  logic [15:0]     shreg;
  logic            pend;
  logic            auto_start;
  logic            req;
  logic            start;

  // Idle line level is high (nothing pressed), so the synchroniser resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], con_data};
    end
  end

  assign data_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (pc == PC_LAST) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  assign auto_start = (pc == PC_LAST);
  assign req        = auto_start | poll_req;
  assign start      = req | pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bi          <= 4'd0;
      shreg       <= 16'h0000;
      pend        <= 1'b0;
      con_latch   <= 1'b0;
      con_clk     <= 1'b1;
      con_state   <= 16'h0000;
      state_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Requests arriving mid-read collapse into a single pending read.
      if (state == S_IDLE) begin
        if (start) begin
          pend <= 1'b0;
        end
      end else if (req) begin
        pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          state_valid <= 1'b0;
          if (start) begin
            state     <= S_LATCH;
            cnt       <= '0;
            shreg     <= 16'h0000;
            con_latch <= 1'b1;
            con_clk   <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_LATCH: begin
          if (cnt == LATCH_LAST) begin
            state     <= S_LOW;
            cnt       <= '0;
            bi        <= 4'd0;
            con_latch <= 1'b0;
            con_clk   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_LOW: begin
          if (cnt == HALF_LAST) begin
            // Sample as late as possible so the bit has settled through the synchroniser.
            shreg[bi] <= ~data_s;
            state     <= S_HIGH;
            cnt       <= '0;
            con_clk   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (bi == 4'd15) begin
              state       <= S_DONE;
              con_state   <= shreg;
              state_valid <= 1'b1;
            end else begin
              state   <= S_LOW;
              bi      <= bi + 4'd1;
              con_clk <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          state       <= S_IDLE;
          state_valid <= 1'b0;
          busy        <= 1'b0;
        end

        default: begin
          state       <= S_IDLE;
          con_latch   <= 1'b0;
          con_clk     <= 1'b1;
          state_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_con_reader.sv
`default_nettype none
`timescale 1ns/1ps
// tb_con_reader: table vectors, directed corner sequences and a random run,
// all cross-checked every cycle against a schedule-level reference model.
module tb_con_reader;

  localparam int L      = 4;
  localparam int H      = 3;
  localparam int P      = 400;
  localparam int DONE_T = L + 32 * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        poll_req = 1'b0;
  logic        con_data;
  logic        con_latch;
  logic        con_clk;
  logic [15:0] con_state;
  logic        state_valid;
  logic        busy;

  logic [15:0] padraw = 16'hFFFF;
  int          pad_idx = 16;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  con_reader #(
    .POLL_CYCLES (P),
    .LATCH_CYCLES(L),
    .HALF_CYCLES (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .poll_req   (poll_req),
    .con_data   (con_data),
    .con_latch  (con_latch),
    .con_clk    (con_clk),
    .con_state  (con_state),
    .state_valid(state_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad: bit 0 presented while latched, next bit on each con_clk rising edge.
  always @(posedge con_latch or posedge con_clk) begin
    if (con_latch) pad_idx = 0;
    else if (pad_idx < 16) pad_idx = pad_idx + 1;
  end
  assign con_data = (pad_idx < 16) ? padraw[pad_idx[3:0]] : 1'b0;

  // Reference model: m_t is cycles since the read's first LATCH cycle, -1 when idle.
  int          m_pc = 0;
  int          m_t = -1;
  bit          m_pend = 1'b0;
  bit          m_req;
  logic [15:0] m_word = 16'h0000;
  logic [15:0] m_raw = 16'hFFFF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 0; m_t = -1; m_pend = 1'b0; m_word = 16'h0000;
    end else begin
      m_req = (m_pc == P - 1) || (poll_req === 1'b1);
      if (m_t < 0) begin
        if (m_req || m_pend) begin
          m_t = 0; m_pend = 1'b0; m_raw = padraw;
        end
      end else begin
        if (m_req) m_pend = 1'b1;
        if (m_t == DONE_T) m_t = -1;
        else begin
          m_t = m_t + 1;
          if (m_t == DONE_T) m_word = ~m_raw;
        end
      end
      m_pc = (m_pc == P - 1) ? 0 : m_pc + 1;
    end
  end

  function automatic logic exp_clk(input int t);
    if (t < L || t >= L + 32 * H) return 1'b1;
    return (((t - L) / H) % 2) == 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    logic [19:0] got, want;
    @(negedge clk);
    if (!rst) begin
      got  = {con_latch, con_clk, busy, state_valid, con_state};
      want = {(m_t >= 0 && m_t < L), exp_clk(m_t), (m_t >= 0), (m_t == DONE_T), m_word};
      check("cycle", {12'd0, got}, {12'd0, want});
    end
  endtask

  task automatic pulse_poll();
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
  endtask

  task automatic wait_pc(input int v);
    int n = 0;
    while (m_pc != v && n < 2 * P) begin tick(); n++; end
    check("wait_pc", m_pc, v);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (state_valid !== 1'b1 && n < 300) begin tick(); n++; end
    check({"valid_", name}, {31'd0, state_valid}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] raw;
    logic [15:0] want;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int c0, cl, w, d, n, nv, bh;
    bit seen;
    logic [15:0] cap;

    vecs[0] = '{16'hFFFE, 16'h0001};
    vecs[1] = '{16'h0F7E, 16'hF081};
    vecs[2] = '{16'hFFFF, 16'h0000};
    vecs[3] = '{16'h0000, 16'hFFFF};
    vecs[4] = '{16'hA5C3, 16'h5A3C};

    repeat (3) @(negedge clk);
    check("rst_latch", {31'd0, con_latch}, 32'd0);
    check("rst_clk",   {31'd0, con_clk},   32'd1);
    check("rst_state", {16'd0, con_state}, 32'd0);
    check("rst_valid", {31'd0, state_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);

    // Automatic poll with no requests
    padraw = 16'hFFFE;
    rst = 1'b0;
    c0 = cyc;
    n = 0;
    while (con_latch !== 1'b1 && n < 500) begin tick(); n++; end
    check("first_latch_cycle", cyc - c0, P);
    cl = cyc;
    w = 0;
    while (con_latch === 1'b1 && w < 10) begin w++; tick(); end
    check("latch_width", w, L);
    wait_valid("auto");
    check("valid_offset", cyc - cl, DONE_T);
    check("auto_word", {16'd0, con_state}, 32'h0001);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      wait_pc(150);
      padraw = vecs[i].raw;
      pulse_poll();
      wait_valid("vec");
      check("vec_word", {16'd0, con_state}, {16'd0, vecs[i].want});
      check("busy_in_done", {31'd0, busy}, 32'd1);
    end

    // Two extra requests while busy merge into one pending read
    wait_pc(150);
    padraw = 16'h7FFF;
    pulse_poll();
    repeat (10) tick();
    pulse_poll();
    repeat (20) tick();
    pulse_poll();
    wait_valid("pend_a");
    d = cyc;
    n = 0;
    while (con_latch !== 1'b1 && n < 10) begin tick(); n++; end
    check("pend_latch_gap", cyc - d, 2);
    wait_valid("pend_b");
    check("pend_word", {16'd0, con_state}, 32'h8000);
    n = 0;
    while (m_pc != 398) begin
      tick();
      if (con_latch === 1'b1 || state_valid === 1'b1) n++;
    end
    check("extra_reads", n, 0);

    // auto_start and poll_req coincide in IDLE
    wait_pc(399);
    padraw = 16'hFFDF;
    pulse_poll();
    nv = 0; bh = 0; seen = 1'b0; cap = 16'h0;
    for (int i = 0; i < 390; i++) begin
      tick();
      if (state_valid === 1'b1) begin nv++; seen = 1'b1; cap = con_state; end
      else if (seen && busy !== 1'b0) bh++;
    end
    check("sim_reads", nv, 1);
    check("sim_word", {16'd0, cap}, 32'h0020);
    check("busy_after_done", bh, 0);

    // Reset during bit 7 LOW
    wait_pc(150);
    padraw = 16'hFF00;
    pulse_poll();
    n = 0;
    while (m_t != L + 14 * H + 1 && n < 200) begin tick(); n++; end
    check("bit7_reached", m_t, L + 14 * H + 1);
    check("bit7_clk_low", {31'd0, con_clk}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_latch", {31'd0, con_latch}, 32'd0);
    check("mid_rst_clk",   {31'd0, con_clk},   32'd1);
    check("mid_rst_state", {16'd0, con_state}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (state_valid === 1'b1) nv++;
    end
    check("no_valid_after_rst", nv, 0);
    pulse_poll();
    wait_valid("post_rst");
    check("post_rst_word", {16'd0, con_state}, 32'h00FF);

    // Random requests and pad words against the model
    for (int i = 0; i < 3000; i++) begin
      poll_req = ($urandom_range(0, 99) < 3);
      if (m_t < 0 && $urandom_range(0, 9) == 0) padraw = 16'($urandom);
      tick();
    end
    poll_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
